// File: rtl/forward_space_seq_pkg.sv
// Shared constants, state encoding and cube-root helper for forward_space_seq.
// Optional pixel counter is enabled with FWD_SEQ_PIXEL_COUNT_EN.
package forward_space_seq_pkg;

    localparam int DEF_SIZE_INT  = 32;
    localparam int DEF_SCALE_BIT = 8;

    localparam int C_XR = 106;
    localparam int C_XG = 92;
    localparam int C_XB = 46;
    localparam int C_YR = 54;
    localparam int C_YG = 183;
    localparam int C_YB = 18;
    localparam int C_ZR = 5;
    localparam int C_ZG = 31;
    localparam int C_ZB = 243;

    localparam int WP_X     = 269;
    localparam int WP_Z     = 235;
    localparam int WP_SHIFT = 8;

    localparam int CLAMP_LO = 2;
    localparam int CLAMP_HI = 256;

    localparam int L_MUL = 116;
    localparam int L_OFF = 26008;
    localparam int A_MUL = 500;
    localparam int B_MUL = 200;

    typedef enum logic [2:0] {
        IDLE,
        MATRIX,
        LUT_X,
        LUT_Y,
        LUT_Z,
        DONE
    } state_t;

    // floor(cbrt(n)); with n = i << 24 this is floor(256 * cbrt(i))
    function automatic logic [15:0] icbrt(input logic [63:0] n);
        logic [15:0] r;
        logic [15:0] t;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            t = r | 16'(1 << b);
            if (64'(t) * 64'(t) * 64'(t) <= n) r = t;
        end
        return r;
    endfunction

endpackage

// File: rtl/forward_space_seq_if.sv
// Pixel-in / Lab-out handshake bundle for forward_space_seq.
// Optional pixel counter (FWD_SEQ_PIXEL_COUNT_EN) stays a plain port.
import forward_space_seq_pkg::*;

interface forward_space_seq_if #(
    parameter int SIZE_INT = DEF_SIZE_INT
);
    logic                       in_valid;
    logic                       in_ready;
    logic [SIZE_INT-1:0]        R;
    logic [SIZE_INT-1:0]        G;
    logic [SIZE_INT-1:0]        B;
    logic                       out_valid;
    logic                       out_ready;
    logic [SIZE_INT-1:0]        CIEL;
    logic signed [SIZE_INT-1:0] CIEa;
    logic signed [SIZE_INT-1:0] CIEb;

    modport master (
        output in_valid, R, G, B, out_ready,
        input  in_ready, out_valid, CIEL, CIEa, CIEb
    );

    modport slave (
        input  in_valid, R, G, B, out_ready,
        output in_ready, out_valid, CIEL, CIEa, CIEb
    );
endinterface

// File: rtl/forward_space_seq_cube_root_lut.sv
// Combinational cube-root ROM: val = floor(256 * cbrt(idx)).
// Built at elaboration; used by forward_space_seq (FWD_SEQ_PIXEL_COUNT_EN agnostic).
import forward_space_seq_pkg::*;

module cube_root_lut #(
    parameter int SIZE_INT = DEF_SIZE_INT
) (
    input  logic [8:0]          idx,
    output logic [SIZE_INT-1:0] val
);
    logic [SIZE_INT-1:0] rom [512];

    for (genvar i = 0; i < 512; i++) begin : g_rom
        localparam logic [15:0] V = icbrt(64'(i) << 24);
        assign rom[i] = SIZE_INT'(V);
    end

    assign val = rom[idx];
endmodule

// File: rtl/forward_space_seq.sv
// Sequential RGB -> XYZ -> CIE Lab converter sharing one cube-root LUT.
// Define FWD_SEQ_PIXEL_COUNT_EN to add the pixel_count output.
import forward_space_seq_pkg::*;

module forward_space_seq #(
    parameter int SIZE_INT  = DEF_SIZE_INT,
    parameter int SCALE_BIT = DEF_SCALE_BIT
) (
    input  logic               clk,
    input  logic               rst_n,
    forward_space_seq_if.slave bus,
    output logic               busy
`ifdef FWD_SEQ_PIXEL_COUNT_EN
    ,
    output logic [15:0]        pixel_count
`endif
);
    localparam int MW = SIZE_INT + 10;

    state_t state;

    logic [SIZE_INT-1:0] r_q, g_q, b_q;
    logic [SIZE_INT-1:0] fx_q, fy_q, lut_q;
    logic [8:0]          x_q, y_q, z_q, lut_idx;
    logic                in_ready_q, out_valid_q;
    logic [SIZE_INT-1:0] ciel_q, ciea_q, cieb_q;

    logic [MW-1:0]       sx, sy, sz, xw, zw;
    logic [8:0]          x_c, y_c, z_c;
    logic [SIZE_INT-1:0] ciel_n, ciea_n, cieb_n;

    function automatic logic [8:0] clamp(input logic [MW-1:0] v);
        if (v < MW'(CLAMP_LO)) return 9'(CLAMP_LO);
        if (v > MW'(CLAMP_HI)) return 9'(CLAMP_HI);
        return v[8:0];
    endfunction

    always_comb begin
        sx = MW'(r_q) * MW'(C_XR) + MW'(g_q) * MW'(C_XG)
           + MW'(b_q) * MW'(C_XB);
        sy = MW'(r_q) * MW'(C_YR) + MW'(g_q) * MW'(C_YG)
           + MW'(b_q) * MW'(C_YB);
        sz = MW'(r_q) * MW'(C_ZR) + MW'(g_q) * MW'(C_ZG)
           + MW'(b_q) * MW'(C_ZB);
        xw = ((sx >> (2 * SCALE_BIT)) * MW'(WP_X)) >> WP_SHIFT;
        zw = ((sz >> (2 * SCALE_BIT)) * MW'(WP_Z)) >> WP_SHIFT;
        x_c = clamp(xw);
        y_c = clamp(sy >> (2 * SCALE_BIT));
        z_c = clamp(zw);
    end

    always_comb begin
        lut_idx = x_q;
        unique case (1'b1)
            (state == LUT_Y): lut_idx = y_q;
            (state == LUT_Z): lut_idx = z_q;
            default:          lut_idx = x_q;
        endcase
    end

    cube_root_lut #(.SIZE_INT(SIZE_INT)) u_lut (
        .idx (lut_idx),
        .val (lut_q)
    );

    // fZ is consumed straight from the LUT on the LUT_Z edge
    always_comb begin
        ciel_n = SIZE_INT'(L_MUL) * fy_q - SIZE_INT'(L_OFF);
        ciea_n = SIZE_INT'(A_MUL) * (fx_q - fy_q);
        cieb_n = SIZE_INT'(B_MUL) * (fy_q - lut_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            ciel_q      <= '0;
            ciea_q      <= '0;
            cieb_q      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (bus.in_valid && in_ready_q) begin
                        r_q        <= bus.R;
                        g_q        <= bus.G;
                        b_q        <= bus.B;
                        in_ready_q <= 1'b0;
                        state      <= MATRIX;
                    end
                end
                MATRIX: begin
                    x_q   <= x_c;
                    y_q   <= y_c;
                    z_q   <= z_c;
                    state <= LUT_X;
                end
                LUT_X: begin
                    fx_q  <= lut_q;
                    state <= LUT_Y;
                end
                LUT_Y: begin
                    fy_q  <= lut_q;
                    state <= LUT_Z;
                end
                LUT_Z: begin
                    ciel_q      <= ciel_n;
                    ciea_q      <= ciea_n;
                    cieb_q      <= cieb_n;
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FWD_SEQ_PIXEL_COUNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            pixel_count <= '0;
        else if (state == DONE && bus.out_ready)
            pixel_count <= pixel_count + 16'd1;
    end
`endif

    assign busy          = (state != IDLE);
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.CIEL      = ciel_q;
    assign bus.CIEa      = ciea_q;
    assign bus.CIEb      = cieb_q;
endmodule
